// File: rtl/state_2bit.sv
// state_2bit: two-bit sequencer stepping 00 -> 01 -> 10 -> 11 -> 00.
// reset (synchronous) beats stop, stop beats show, and show=0 holds.
// q is taken straight from the state register, so it has no combinational
// path from the inputs.
module state_2bit (
  output logic [1:0] q,
  input  logic       stop,
  input  logic       show,
  input  logic       reset,
  input  logic       clk
);

  // The state code is the output code, so no decode is needed.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_adv;

  // Successor in the fixed cycle.  S3 wraps to S0 and raises no flag.
  always_comb begin
    w_adv = S0;
    unique case (r_state)
      S0: w_adv = S1;
      S1: w_adv = S2;
      S2: w_adv = S3;
      S3: w_adv = S0;
      default: w_adv = S0;
    endcase
  end

  // Next state: stop freezes, show advances, and otherwise hold.
  // Reset is not handled here; it is applied in the register.
  always_comb begin
    w_next = r_state;
    if (stop)      w_next = r_state;
    else if (show) w_next = w_adv;
  end

  // State register with synchronous reset.  Reset overrides the next-state
  // logic, so X on stop or show cannot leak through while reset is high.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  assign q = r_state;

endmodule

// File: tb/tb_state_2bit.sv
// tb_state_2bit: directed test plan followed by random stimulus.  Each edge is
// checked against a counter model that implements the priority rules directly.
module tb_state_2bit;

  logic       clk = 1'b0;
  logic       reset, stop, show;
  logic [1:0] q;

  int n_vec  = 0;
  int n_miss = 0;
  int mdl    = 0;   // reference count 0..3; it becomes valid after the first reset

  state_2bit dut (
    .q     (q),
    .stop  (stop),
    .show  (show),
    .reset (reset),
    .clk   (clk)
  );

  always #5 clk = ~clk;

  // Drive inputs at the falling edge, then clock one rising edge.
  // Update the model, then sample q #1 after the rising edge.
  // exp < 0 means there is no directed value, and only the model is checked.
  task automatic step(input logic r, input logic st, input logic sh,
                      input int exp, input string tag);
    logic [1:0] m;
    @(negedge clk);
    reset = r; stop = st; show = sh;
    @(posedge clk);
    if (r)       mdl = 0;
    else if (st) mdl = mdl;
    else if (sh) mdl = (mdl + 1) % 4;
    #1;
    m = 2'(mdl);
    n_vec++;
    assert (q === m) else begin
      n_miss++;
      $error("FAIL %s model: q=%b expected %b", tag, q, m);
    end
    if (exp >= 0) begin
      n_vec++;
      assert (q === 2'(exp)) else begin
        n_miss++;
        $error("FAIL %s plan: q=%b expected %b", tag, q, 2'(exp));
      end
    end
  endtask

  initial begin
    reset = 1'b0; stop = 1'b0; show = 1'b0;

    // Reset: hold reset for 2 edges with show=1.
    step(1, 0, 1, 0, "reset1");
    step(1, 0, 1, 0, "reset2");
    // Idle: release reset with show=0 for 3 edges.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "idle");
    // Run for 9 edges and check the wrap twice.
    step(0, 0, 1, 1, "run1");
    step(0, 0, 1, 2, "run2");
    step(0, 0, 1, 3, "run3");
    step(0, 0, 1, 0, "run4");
    step(0, 0, 1, 1, "run5");
    step(0, 0, 1, 2, "run6");
    step(0, 0, 1, 3, "run7");
    step(0, 0, 1, 0, "run8");
    step(0, 0, 1, 1, "run9");
    step(0, 0, 1, 2, "to_s2");
    // Freeze at 10 with stop=1 and show=1, then drop stop.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2, "freeze");
    step(0, 0, 1, 3, "unfreeze");
    // Pause at 11 with show=0, then raise show.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3, "pause");
    step(0, 0, 1, 0, "resume");
    step(0, 0, 1, 1, "to_s1");
    step(0, 0, 1, 2, "to_s2b");
    // Mid-run reset at 10 with stop=1 and show=1.
    step(1, 1, 1, 0, "midreset");
    step(0, 0, 1, 1, "post_reset");

    // Random stimulus.  Reset is rare, so long runs of stepping still occur.
    for (int i = 0; i < 400; i++) begin
      logic r, st, sh;
      r  = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 3) == 0);
      sh = ($urandom_range(0, 3) != 0);
      step(r, st, sh, -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
